dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//   Request-side controller directly upstream of dcache. Accepts one word load/store
//   at a time, probes dcache, services misses by reading the line from memory and
//   installing it, and writes back any dirty line dcache ejects. Blocking: one request
//   in flight, no hit-under-miss.
// PARAMETERS
//   addr_width  16  line address width (must equal dcache addr_width)
//   line_width  64  cache line width (must equal dcache line_width)
//   word_width  16  request word width; line_width % word_width == 0, WORDS = line_width/word_width
// PORTS
//   clk_i            in   1             clock
//   rst_ni           in   1             synchronous reset, active low
//   req_valid_i      in   1             request valid
//   req_ready_o      out  1             request accepted when valid&ready
//   req_write_i      in   1             1 = store, 0 = load
//   req_addr_i       in   addr_width    line address
//   req_word_i       in   $clog2(WORDS) word index within line (word 0 = bits [word_width-1:0])
//   req_data_i       in   word_width    store data
//   resp_valid_o     out  1             one-cycle completion pulse (load and store)
//   resp_data_o      out  word_width    load data, valid with resp_valid_o
//   c_addr_o         out  addr_width    to dcache addr_i
//   c_r_valid_o      out  1             to dcache r_valid_i
//   c_r_valid_i      in   1             from dcache r_valid_o
//   c_r_miss_i       in   1             from dcache r_miss_o
//   c_read_i         in   line_width    from dcache read_o
//   c_w_valid_o      out  1             to dcache w_valid_i
//   c_dirty_o        out  1             to dcache dirty_i
//   c_write_o        out  line_width    to dcache write_i
//   c_ej_valid_i     in   1             from dcache ejected_valid_o
//   c_ej_addr_i      in   addr_width    from dcache ejected_addr_o
//   c_ej_data_i      in   line_width    from dcache ejected_o
//   mem_req_valid_o  out  1             memory request valid
//   mem_req_ready_i  in   1             memory accepts when valid&ready
//   mem_req_write_o  out  1             1 = line write, 0 = line read
//   mem_req_addr_o   out  addr_width    line address
//   mem_req_data_o   out  line_width    write data
//   mem_resp_valid_i in   1             read data valid (one pulse per read; writes get none)
//   mem_resp_data_i  in   line_width    read line
// BEHAVIOUR
//   - Reset (rst_ni=0 at clk edge): state IDLE; every output 0 except req_ready_o=0 during
//     reset and 1 in the first IDLE cycle after. Reset mid-operation abandons the request,
//     no response; any outstanding memory transaction is dropped (memory reset together).
//   - States: IDLE, PROBE, CHECK, FILL_REQ, FILL_WAIT, INSTALL, EJECT, WB_REQ, RESP.
//   - IDLE: req_ready_o=1; on handshake latch write/addr/word/data -> PROBE. Ready 0 elsewhere.
//   - PROBE: c_r_valid_o=1, c_addr_o=latched addr -> CHECK.
//   - CHECK (c_r_valid_i=1): hit&load -> RESP with data = word of c_read_i.
//     hit&store -> INSTALL with line = c_read_i, word replaced, dirty=1.
//     miss -> FILL_REQ.
//   - FILL_REQ: mem_req_valid_o=1, write=0, addr=latched; hold until ready -> FILL_WAIT.
//   - FILL_WAIT: on mem_resp_valid_i latch line (store: merge word) -> INSTALL.
//   - INSTALL: c_w_valid_o=1, c_r_valid_o=0, c_addr_o=latched addr, c_dirty_o = 1 if store
//     else (hit ? 1 : 0), c_write_o = line -> EJECT. c_addr_o held at latched addr through EJECT.
//   - EJECT: sample c_ej_valid_i; if 1 latch c_ej_addr_i/c_ej_data_i -> WB_REQ, else -> RESP.
//     Ejection never occurs on a hit (tag matches); must still be sampled.
//   - WB_REQ: mem_req_valid_o=1, write=1, addr/data = ejected; hold until ready -> RESP.
//   - RESP: resp_valid_o=1 for exactly one cycle (resp_data_o = load word; 0 for stores) -> IDLE.
//   - Latency accept->resp_valid: load hit 3 cycles; store hit 5; miss = 5 + memory
//     read wait + write-back wait. Throughput: one request per completion.
//   - c_r_valid_o and c_w_valid_o are never high together; mem_req_* held stable while
//     valid&!ready. resp has no back-pressure.
// TESTING
//   - Load miss to addr 0x0010 on empty cache, mem returns 0x4444_3333_2222_1111, word 2
//     -> one mem read 0x0010, install clean, resp_data 0x3333; repeat -> hit, resp 3 cycles after accept.
//   - Store 0xBEEF word 1 to 0x0010 (hit) -> line 0x4444_3333_BEEF_1111 written dirty,
//     no memory traffic, resp at cycle 5.
//   - Load 0x0050 (same set, depth 64) -> mem read 0x0050, then mem write addr 0x0010
//     data 0x4444_3333_BEEF_1111.
//   - Load miss to clean line in same set -> mem read only, no write-back.
//   - mem_req_ready_i low 10 cycles in FILL_REQ and WB_REQ -> signals held stable, single request each.
//   - rst_ni low in FILL_WAIT -> all outputs 0, no resp; next request handled normally.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking request-side controller in front of dcache. It probes the cache,
// fills misses from memory, installs the line and writes back any dirty line dcache ejects.
module dcache_ctrl #(
    parameter int addr_width = 16,
    parameter int line_width = 64,
    parameter int word_width = 16,
    localparam int WORDS = line_width / word_width,
    localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [addr_width-1:0] req_addr_i,
    input  logic [WIDX-1:0]       req_word_i,
    input  logic [word_width-1:0] req_data_i,
    output logic                  resp_valid_o,
    output logic [word_width-1:0] resp_data_o,
    output logic [addr_width-1:0] c_addr_o,
    output logic                  c_r_valid_o,
    input  logic                  c_r_valid_i,
    input  logic                  c_r_miss_i,
    input  logic [line_width-1:0] c_read_i,
    output logic                  c_w_valid_o,
    output logic                  c_dirty_o,
    output logic [line_width-1:0] c_write_o,
    input  logic                  c_ej_valid_i,
    input  logic [addr_width-1:0] c_ej_addr_i,
    input  logic [line_width-1:0] c_ej_data_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_write_o,
    output logic [addr_width-1:0] mem_req_addr_o,
    output logic [line_width-1:0] mem_req_data_o,
    input  logic                  mem_resp_valid_i,
    input  logic [line_width-1:0] mem_resp_data_i,
    output logic [3:0]            dbg_state_o
);

    // Handshakes (req, mem_req): a transfer happens on a rising clk_i edge where valid and
    // ready are both 1; a raised valid holds, with its payload stable, until that edge.
    // resp_valid_o and mem_resp_valid_i are single-cycle pulses with no back-pressure.

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PROBE     = 4'd1,
        S_CHECK     = 4'd2,
        S_FILL_REQ  = 4'd3,
        S_FILL_WAIT = 4'd4,
        S_INSTALL   = 4'd5,
        S_EJECT     = 4'd6,
        S_WB_REQ    = 4'd7,
        S_RESP      = 4'd8
    } state_t;

    state_t                state;
    logic                  wr_q;
    logic [WIDX-1:0]       word_q;
    logic [word_width-1:0] data_q;
    logic [word_width-1:0] rdata_q;

    assign dbg_state_o = state;

    function automatic logic [word_width-1:0] get_word(input logic [line_width-1:0] line,
                                                       input logic [WIDX-1:0]       idx);
        get_word = '0;
        for (int i = 0; i < WORDS; i++)
            if (idx == i[WIDX-1:0]) get_word = line[i*word_width +: word_width];
    endfunction

    function automatic logic [line_width-1:0] put_word(input logic [line_width-1:0] line,
                                                       input logic [WIDX-1:0]       idx,
                                                       input logic [word_width-1:0] w);
        put_word = line;
        for (int i = 0; i < WORDS; i++)
            if (idx == i[WIDX-1:0]) put_word[i*word_width +: word_width] = w;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= S_IDLE;
            req_ready_o     <= 1'b0;
            resp_valid_o    <= 1'b0;
            resp_data_o     <= '0;
            c_addr_o        <= '0;
            c_r_valid_o     <= 1'b0;
            c_w_valid_o     <= 1'b0;
            c_dirty_o       <= 1'b0;
            c_write_o       <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_write_o <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_data_o  <= '0;
            wr_q            <= 1'b0;
            word_q          <= '0;
            data_q          <= '0;
            rdata_q         <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            c_r_valid_o  <= 1'b0;
            c_w_valid_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        wr_q        <= req_write_i;
                        word_q      <= req_word_i;
                        data_q      <= req_data_i;
                        c_addr_o    <= req_addr_i;
                        c_r_valid_o <= 1'b1;
                        state       <= S_PROBE;
                    end
                end
                S_PROBE: state <= S_CHECK;
                S_CHECK: begin
                    if (c_r_valid_i) begin
                        if (c_r_miss_i) begin
                            mem_req_valid_o <= 1'b1;
                            mem_req_write_o <= 1'b0;
                            mem_req_addr_o  <= c_addr_o;
                            mem_req_data_o  <= '0;
                            state           <= S_FILL_REQ;
                        end else if (!wr_q) begin
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= get_word(c_read_i, word_q);
                            state        <= S_RESP;
                        end else begin
                            c_w_valid_o <= 1'b1;
                            c_dirty_o   <= 1'b1;
                            c_write_o   <= put_word(c_read_i, word_q, data_q);
                            rdata_q     <= '0;
                            state       <= S_INSTALL;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        mem_req_addr_o  <= '0;
                        state           <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_resp_valid_i) begin
                        c_w_valid_o <= 1'b1;
                        c_dirty_o   <= wr_q;
                        c_write_o   <= wr_q ? put_word(mem_resp_data_i, word_q, data_q)
                                            : mem_resp_data_i;
                        rdata_q     <= wr_q ? '0 : get_word(mem_resp_data_i, word_q);
                        state       <= S_INSTALL;
                    end
                end
                S_INSTALL: state <= S_EJECT;
                S_EJECT: begin
                    // dcache reports the victim one cycle after the install write.
                    c_dirty_o <= 1'b0;
                    c_write_o <= '0;
                    if (c_ej_valid_i) begin
                        mem_req_valid_o <= 1'b1;
                        mem_req_write_o <= 1'b1;
                        mem_req_addr_o  <= c_ej_addr_i;
                        mem_req_data_o  <= c_ej_data_i;
                        state           <= S_WB_REQ;
                    end else begin
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= rdata_q;
                        state        <= S_RESP;
                    end
                end
                S_WB_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        mem_req_write_o <= 1'b0;
                        mem_req_addr_o  <= '0;
                        mem_req_data_o  <= '0;
                        resp_valid_o    <= 1'b1;
                        resp_data_o     <= rdata_q;
                        state           <= S_RESP;
                    end
                end
                S_RESP: begin
                    req_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed cases plus random traffic against a behavioural model of
// architectural memory and cache tags, with dcache and memory responders around the DUT.
module tb_dcache_ctrl;
  localparam int AW = 16;
  localparam int LW = 64;
  localparam int WW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [1:0]    req_word_i = '0;
  logic [WW-1:0] req_data_i = '0;
  logic          resp_valid_o;
  logic [WW-1:0] resp_data_o;
  logic [AW-1:0] c_addr_o;
  logic          c_r_valid_o;
  logic          c_r_valid_i = 1'b0;
  logic          c_r_miss_i = 1'b0;
  logic [LW-1:0] c_read_i = '0;
  logic          c_w_valid_o;
  logic          c_dirty_o;
  logic [LW-1:0] c_write_o;
  logic          c_ej_valid_i = 1'b0;
  logic [AW-1:0] c_ej_addr_i = '0;
  logic [LW-1:0] c_ej_data_i = '0;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b1;
  logic          mem_req_write_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [LW-1:0] mem_req_data_o;
  logic          mem_resp_valid_i = 1'b0;
  logic [LW-1:0] mem_resp_data_i = '0;
  logic [3:0]    dbg_state_o;

  dcache_ctrl #(.addr_width(AW), .line_width(LW), .word_width(WW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_word_i(req_word_i), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .c_addr_o(c_addr_o), .c_r_valid_o(c_r_valid_o), .c_r_valid_i(c_r_valid_i),
    .c_r_miss_i(c_r_miss_i), .c_read_i(c_read_i), .c_w_valid_o(c_w_valid_o),
    .c_dirty_o(c_dirty_o), .c_write_o(c_write_o), .c_ej_valid_i(c_ej_valid_i),
    .c_ej_addr_i(c_ej_addr_i), .c_ej_data_i(c_ej_data_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_write_o(mem_req_write_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WW-1:0] exp_q[$];       // expected response words
  logic [80:0]   mem_exp_q[$];   // {write, addr, data (0 for reads)}
  logic [80:0]   inst_q[$];      // {dirty, addr, line}

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    if (a == 16'h0010) return 64'h4444_3333_2222_1111;
    return {a ^ 16'hA5A5, a + 16'h0101, ~a, a};
  endfunction

  // ---------------- reference model: architectural memory + tag table ----------------
  logic [LW-1:0] gold[int];
  bit            ref_valid[64];
  bit            ref_dirty[64];
  logic [AW-1:0] ref_tag[64];

  function automatic logic [LW-1:0] gold_get(input logic [AW-1:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : init_line(a);
  endfunction

  task automatic plan_req(input bit w, input logic [AW-1:0] a, input int wd,
                          input logic [WW-1:0] d, output bit hit);
    int s;
    logic [LW-1:0] line;
    s = int'(a % 64);
    hit = ref_valid[s] && (ref_tag[s] == a);
    line = gold_get(a);
    if (!hit) begin
      mem_exp_q.push_back({1'b0, a, 64'h0});
      if (ref_valid[s] && ref_dirty[s])
        mem_exp_q.push_back({1'b1, ref_tag[s], gold_get(ref_tag[s])});
    end
    if (w) begin
      line[wd*WW +: WW] = d;
      gold[int'(a)] = line;
    end
    exp_q.push_back(w ? 16'h0 : line[wd*WW +: WW]);
    if (w || !hit) inst_q.push_back({w, a, line});
    ref_dirty[s] = hit ? (ref_dirty[s] | w) : w;
    ref_valid[s] = 1'b1;
    ref_tag[s] = a;
  endtask

  // ---------------- dcache responder (direct mapped, 64 sets) ----------------
  bit            dc_valid[64];
  bit            dc_dirty[64];
  logic [AW-1:0] dc_tag[64];
  logic [LW-1:0] dc_data[64];

  always @(posedge clk_i) begin
    int s;
    logic [80:0] e;
    c_r_valid_i  <= 1'b0;
    c_ej_valid_i <= 1'b0;
    if (c_r_valid_o || c_w_valid_o) chk("rw_exclusive", c_r_valid_o && c_w_valid_o, 0);
    s = int'(c_addr_o % 64);
    if (c_r_valid_o) begin
      c_r_valid_i <= 1'b1;
      c_r_miss_i  <= !(dc_valid[s] && dc_tag[s] == c_addr_o);
      c_read_i    <= dc_data[s];
    end
    if (c_w_valid_o) begin
      if (inst_q.size() == 0) chk("install_unexpected", 1, 0);
      else begin
        e = inst_q.pop_front();
        chk("install", {c_dirty_o, c_addr_o, c_write_o}, e);
      end
      if (dc_valid[s] && dc_dirty[s] && dc_tag[s] != c_addr_o) begin
        c_ej_valid_i <= 1'b1;
        c_ej_addr_i  <= dc_tag[s];
        c_ej_data_i  <= dc_data[s];
      end
      dc_valid[s] = 1'b1;
      dc_dirty[s] = c_dirty_o;
      dc_tag[s]   = c_addr_o;
      dc_data[s]  = c_write_o;
    end
  end

  // ---------------- memory responder ----------------
  typedef struct { int due; logic [LW-1:0] data; } pend_t;
  pend_t         pend_q[$];
  logic [LW-1:0] mem_arr[int];
  int            cyc = 0;
  int            mem_rd_cnt = 0;
  bit            hold_resp = 1'b0;
  bit            stall_flag = 1'b0;
  logic [81:0]   snap = '0;
  int            stall_n = 0;
  bit            rand_ready = 1'b0;
  int            stall_cnt = 0;

  function automatic logic [LW-1:0] mem_get(input logic [AW-1:0] a);
    return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : init_line(a);
  endfunction

  always @(posedge clk_i) begin
    pend_t p;
    logic [80:0] e;
    cyc++;
    mem_resp_valid_i <= 1'b0;
    mem_resp_data_i  <= '0;
    if (!rst_ni) begin
      pend_q.delete();
      stall_flag = 1'b0;
    end else begin
      if (stall_flag)
        chk("mem_hold", {mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_data_o}, snap);
      stall_flag = mem_req_valid_o && !mem_req_ready_i;
      snap = {mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_data_o};
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (mem_exp_q.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          e = mem_exp_q.pop_front();
          chk("mem_req", {mem_req_write_o, mem_req_addr_o,
                          mem_req_write_o ? mem_req_data_o : 64'h0}, e);
        end
        if (mem_req_write_o) mem_arr[int'(mem_req_addr_o)] = mem_req_data_o;
        else begin
          mem_rd_cnt++;
          p.due  = cyc + int'($urandom_range(1, 4));
          p.data = mem_get(mem_req_addr_o);
          pend_q.push_back(p);
        end
      end
      if (!hold_resp && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        mem_resp_valid_i <= 1'b1;
        mem_resp_data_i  <= p.data;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!mem_req_valid_o) begin
      stall_cnt = 0;
      mem_req_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end else if (stall_cnt < stall_n) begin
      stall_cnt++;
      mem_req_ready_i = 1'b0;
    end else begin
      mem_req_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else chk("resp_data", resp_data_o, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit w, input logic [AW-1:0] a, input int wd, input logic [WW-1:0] d);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_word_i  = wd[1:0];
    req_data_i  = d;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [WW-1:0] data);
    bit got = 1'b0;
    lat = 0;
    data = '0;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        got = 1'b1;
        lat = i;
        data = resp_data_o;
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  task automatic do_req(input bit w, input logic [AW-1:0] a, input int wd,
                        input logic [WW-1:0] d, output int lat, output logic [WW-1:0] data);
    bit hit;
    plan_req(w, a, wd, d, hit);
    issue(w, a, wd, d);
    wait_resp(lat, data);
    if (hit && w) chk("store_hit_lat", lat, 5);
    else if (hit) chk("load_hit_lat", lat, 3);
    else chk("miss_lat_min", lat >= 6, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_outs_a", {req_ready_o, resp_valid_o, resp_data_o, c_addr_o, c_r_valid_o,
                       c_w_valid_o, c_dirty_o, c_write_o}, 0);
    chk("rst_outs_b", {mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_data_o}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    int rd0;
    bit hit;
    bit sv_valid, sv_dirty;
    logic [AW-1:0] sv_tag;
    logic [WW-1:0] rd;
    logic [AW-1:0] a;

    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", req_ready_o, 1);

    do_req(1'b0, 16'h0010, 2, 16'h0, lat, rd);
    chk("fill_load_word", rd, 16'h3333);
    do_req(1'b0, 16'h0010, 2, 16'h0, lat, rd);
    chk("hit_load_word", rd, 16'h3333);
    do_req(1'b1, 16'h0010, 1, 16'hBEEF, lat, rd);
    chk("store_resp_zero", rd, 16'h0);
    do_req(1'b0, 16'h0050, 0, 16'h0, lat, rd);
    chk("wb_target_line", mem_get(16'h0010), 64'h4444_3333_BEEF_1111);
    do_req(1'b0, 16'h0090, 3, 16'h0, lat, rd);
    do_req(1'b1, 16'h0090, 0, 16'h1234, lat, rd);

    stall_n = 10;
    do_req(1'b0, 16'h00D0, 1, 16'h0, lat, rd);
    chk("stall_lat_min", lat >= 26, 1);
    stall_n = 0;
    chk("wb_stalled_line", mem_get(16'h0090), gold_get(16'h0090));

    // abandon a load while it waits for fill data
    hold_resp = 1'b1;
    sv_valid = ref_valid[16];
    sv_dirty = ref_dirty[16];
    sv_tag   = ref_tag[16];
    plan_req(1'b0, 16'h0110, 1, 16'h0, hit);
    rd0 = mem_rd_cnt;
    issue(1'b0, 16'h0110, 1, 16'h0);
    n = 0;
    while (mem_rd_cnt == rd0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_fill_seen", mem_rd_cnt != rd0, 1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_reset_outputs();
    void'(exp_q.pop_back());
    void'(inst_q.pop_back());
    ref_valid[16] = sv_valid;
    ref_dirty[16] = sv_dirty;
    ref_tag[16]   = sv_tag;
    hold_resp = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_midreset", req_ready_o, 1);
    do_req(1'b0, 16'h0110, 1, 16'h0, lat, rd);

    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      a = 16'(($urandom_range(0, 3) << 6) | $urandom_range(15, 17));
      do_req(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 3)),
             16'($urandom_range(0, 65535)), lat, rd);
    end

    repeat (5) @(negedge clk_i);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("mem_exp_q_empty", mem_exp_q.size(), 0);
    chk("inst_q_empty", inst_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
